dvp_pattern_tx: RTL and testbench

- DVP (OV5640-style) camera-stream transmitter: emits cam_vsync / cam_href / 8-bit cam_data frames of RGB565 pixels, high byte first.
- It is the transmitting end of the interface our camera capture path receives.
- Used as a sensor stand-in for bring-up, and for bench/board tests of the capture → image_process → DDR3 → LCD chain without a sensor.
- Generates four selectable test patterns with programmable frame geometry and blanking.

---
 rtl/dvp_pattern_tx_if.sv | 8 +
 rtl/dvp_pattern_tx.sv | 100 ++++++++++
 tb/tb_dvp_pattern_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_pattern_tx_if.sv
// dvp_pattern_tx_if: DVP camera bus (vsync, href, byte data) between a sensor-side source and a capture sink.
interface dvp_pattern_tx_if;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;
    modport master (output cam_vsync, cam_href, cam_data);
    modport slave  (input  cam_vsync, cam_href, cam_data);
endinterface

// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: DVP frame transmitter producing RGB565 test patterns, high byte first.
module dvp_pattern_tx #(
    parameter int H_PIXEL  = 640,
    parameter int V_PIXEL  = 480,
    parameter int VS_CLKS  = 8,
    parameter int VBP_CLKS = 32,
    parameter int HB_CLKS  = 16,
    parameter int VFP_CLKS = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_en,
    input  logic [1:0]              pattern_sel,
    dvp_pattern_tx_if.master        cam,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt,
    output logic                    busy
);
    typedef enum logic [2:0] {IDLE, VSYNC, VBP, LINE, HBLANK, VFP} state_t;
    localparam logic [15:0]  VS_LAST   = 16'(VS_CLKS - 1);
    localparam logic [15:0]  VBP_LAST  = 16'(VBP_CLKS - 1);
    localparam logic [15:0]  LINE_LAST = 16'(2 * H_PIXEL - 1);
    localparam logic [15:0]  HB_LAST   = 16'(HB_CLKS - 1);
    localparam logic [15:0]  VFP_LAST  = 16'(VFP_CLKS - 1);
    localparam logic [10:0]  H_LAST    = 11'(H_PIXEL - 1);
    localparam logic [10:0]  V_LAST    = 11'(V_PIXEL - 1);
    localparam logic [7:0]   BAR_LAST  = 8'(H_PIXEL / 8 - 1);
    localparam logic [127:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                     16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
    state_t      state, state_n;
    logic [15:0] cnt, last_cnt, fc_lat, pix;
    logic [10:0] x, y;
    logic [7:0]  bar_px;
    logic [2:0]  bar;
    logic [1:0]  pat;
    logic        done, fend;
    assign last_cnt = state == VSYNC ? VS_LAST : state == VBP ? VBP_LAST :
                      state == LINE ? LINE_LAST : state == HBLANK ? HB_LAST : VFP_LAST;
    assign done = cnt == last_cnt;
    assign fend = state == VFP && done;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = tx_en ? VSYNC : IDLE;
            VSYNC:   state_n = done ? VBP : VSYNC;
            VBP:     state_n = done ? LINE : VBP;
            LINE:    state_n = done ? HBLANK : LINE;
            HBLANK:  state_n = !done ? HBLANK : y == V_LAST ? VFP : LINE;
            VFP:     state_n = !done ? VFP : tx_en ? VSYNC : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        pix = pat == 2'd0 ? BARS[{bar, 4'b0000} +: 16] :
              pat == 2'd1 ? {x[7:3], x[7:2], x[7:3]} :
              pat == 2'd2 ? {16{x[5] ^ y[5]}} :
              16'(x) + 16'(y) + fc_lat;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            x      <= '0;
            y      <= '0;
            bar    <= '0;
            bar_px <= '0;
            pat    <= '0;
            fc_lat <= '0;
        end else begin
            state  <= state_n;
            cnt    <= (state_n != state || state == IDLE) ? '0 : cnt + 16'd1;
            x      <= state != LINE ? '0 : (cnt[0] && x != H_LAST) ? x + 11'd1 : x;
            bar_px <= (state != LINE || (cnt[0] && bar_px == BAR_LAST)) ? '0 : cnt[0] ? bar_px + 8'd1 : bar_px;
            bar    <= state != LINE ? '0 : (cnt[0] && bar_px == BAR_LAST) ? bar + 3'd1 : bar;
            y      <= state == VSYNC ? '0 : (state == HBLANK && done && y != V_LAST) ? y + 11'd1 : y;
            // The diagonal offset uses the count as it stands once this frame begins.
            if (state_n == VSYNC && state != VSYNC) begin
                pat    <= pattern_sel;
                fc_lat <= frame_cnt + {15'd0, fend};
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam.cam_vsync <= 1'b0;
            cam.cam_href  <= 1'b0;
            cam.cam_data  <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            cam.cam_vsync <= state == VSYNC;
            cam.cam_href  <= state == LINE;
            cam.cam_data  <= state != LINE ? 8'h00 : cnt[0] ? pix[7:0] : pix[15:8];
            busy          <= state != IDLE;
            frame_done    <= fend;
            frame_cnt     <= frame_cnt + {15'd0, fend};
        end
    end
endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb_dvp_pattern_tx: directed bench with byte scoreboards for a small and a 64x64 transmitter.
module tb_dvp_pattern_tx;
    logic        clk, rst_n, tx_en, tx_en_b, sb_s;
    logic [1:0]  pat, pat_b;
    logic        frame_done_s, frame_done_b, busy_s, busy_b;
    logic [15:0] frame_cnt_s, frame_cnt_b;
    int          tests, fails, fd_cnt, n, n2, lines, vs_seen, bl, bb;
    logic [7:0]  q_s[$], q_b[$];
    logic [7:0]  hi, prev_href_b;
    logic [15:0] cap [64][64];

    dvp_pattern_tx_if s_if ();
    dvp_pattern_tx_if b_if ();

    dvp_pattern_tx #(.H_PIXEL(16), .V_PIXEL(4), .VS_CLKS(4), .VBP_CLKS(3), .HB_CLKS(6), .VFP_CLKS(5)) dut_s (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .pattern_sel(pat), .cam(s_if),
        .frame_done(frame_done_s), .frame_cnt(frame_cnt_s), .busy(busy_s));

    dvp_pattern_tx #(.H_PIXEL(64), .V_PIXEL(64), .VS_CLKS(4), .VBP_CLKS(3), .HB_CLKS(6), .VFP_CLKS(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en_b), .pattern_sel(pat_b), .cam(b_if),
        .frame_done(frame_done_b), .frame_cnt(frame_cnt_b), .busy(busy_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [15:0] model(input int p, input int x, input int y, input int fc, input int h);
        logic [7:0] xv;
        xv = 8'(x);
        if (p == 1) return {xv[7:3], xv[7:2], xv[7:3]};
        if (p == 2) return (((x / 32) + (y / 32)) % 2 == 1) ? 16'hFFFF : 16'h0000;
        if (p == 3) return 16'(x + y + fc);
        case (x / (h / 8))
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic push(input bit big, input int p, input int fc);
        int h, v;
        logic [15:0] pv;
        h = big ? 64 : 16;
        v = big ? 64 : 4;
        for (int y = 0; y < v; y++)
            for (int x = 0; x < h; x++) begin
                pv = model(p, x, y, fc, h);
                if (big) begin q_b.push_back(pv[15:8]); q_b.push_back(pv[7:0]); end
                else     begin q_s.push_back(pv[15:8]); q_s.push_back(pv[7:0]); end
            end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    function automatic logic sig(input int k);
        case (k)
            0: return s_if.cam_vsync;
            1: return s_if.cam_href;
            2: return busy_s;
            3: return b_if.cam_vsync;
            4: return busy_b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_lvl(input string tag, input int k, input logic v, input int bound, output int cnt);
        cnt = 0;
        while (sig(k) !== v && cnt < bound) begin
            tick(1);
            cnt++;
        end
        chk(tag, 32'(cnt < bound), 32'd1);
    endtask

    // Small DUT: scoreboard and frame_done counter.
    always @(negedge clk) begin
        if (frame_done_s) fd_cnt++;
        if (sb_s && s_if.cam_href) begin
            if (q_s.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL s_extra_byte observed=%0h expected=none", s_if.cam_data);
            end else chk("s_byte", 32'(s_if.cam_data), 32'(q_s.pop_front()));
        end
    end

    // Big DUT: scoreboard plus a per-pixel capture for directed spot checks.
    always @(negedge clk) begin
        if (b_if.cam_vsync) begin bl = 0; bb = 0; end
        if (b_if.cam_href) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL b_extra_byte observed=%0h expected=none", b_if.cam_data);
            end else chk("b_byte", 32'(b_if.cam_data), 32'(q_b.pop_front()));
            if (bb % 2 == 0) hi = b_if.cam_data;
            else if (bl < 64 && bb < 128) cap[bl][bb / 2] = {hi, b_if.cam_data};
            bb++;
        end
        if (prev_href_b[0] && !b_if.cam_href) begin bl++; bb = 0; end
        prev_href_b = {7'd0, b_if.cam_href};
    end

    initial begin
        tests = 0; fails = 0; fd_cnt = 0; bl = 0; bb = 0; prev_href_b = '0; hi = '0;
        rst_n = 1'b0; tx_en = 1'b0; tx_en_b = 1'b0; pat = 2'd0; pat_b = 2'd0; sb_s = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(50);
        chk("idle_bus", 32'({s_if.cam_vsync, s_if.cam_href, s_if.cam_data}), 32'd0);
        chk("idle_busy", 32'(busy_s), 32'd0);
        chk("idle_done_cnt", 32'({frame_done_s, frame_cnt_s}), 32'd0);

        // Frame 1 (bars), frame 2 (ramp, selected mid-frame 1).
        push(0, 0, 0);
        push(0, 1, 0);
        tx_en = 1'b1;
        tick(1);
        chk("vsync_lat1", 32'(s_if.cam_vsync), 32'd0);
        tick(1);
        chk("vsync_lat2", 32'(s_if.cam_vsync), 32'd1);
        pat = 2'd1;
        wait_lvl("to_vs_fall", 0, 1'b0, 50, n);
        chk("vsync_width", n, 4);
        n2 = n;
        chk("no_href_in_vsync", 32'(s_if.cam_href), 32'd0);
        wait_lvl("to_href", 1, 1'b1, 50, n);
        chk("vbp_gap", n, 3);
        n2 += n;
        for (int l = 0; l < 4; l++) begin
            wait_lvl("to_href_fall", 1, 1'b0, 100, n);
            chk("href_len", n, 32);
            n2 += n;
            if (l < 3) begin
                wait_lvl("to_href_rise", 1, 1'b1, 50, n);
                chk("hblank_len", n, 6);
                n2 += n;
            end
        end
        wait_lvl("to_vs2", 0, 1'b1, 100, n);
        n2 += n;
        chk("frame_len", n2, 164);
        chk("fd_once", fd_cnt, 1);
        chk("frame_cnt_1", 32'(frame_cnt_s), 32'd1);

        // Drop tx_en and change pattern during line 2 of frame 2.
        lines = 0; n = 0;
        while (lines < 3 && n < 500) begin
            logic prev;
            prev = s_if.cam_href;
            tick(1);
            if (!prev && s_if.cam_href) lines++;
            n++;
        end
        chk("line2_found", 32'(lines), 32'd3);
        tick(5);
        tx_en = 1'b0;
        pat = 2'd2;
        wait_lvl("to_idle", 2, 1'b0, 600, n);
        vs_seen = 0;
        repeat (100) begin
            tick(1);
            if (s_if.cam_vsync) vs_seen++;
        end
        chk("no_new_vsync", vs_seen, 0);
        chk("busy_idle", 32'(busy_s), 32'd0);
        chk("frame_cnt_2", 32'(frame_cnt_s), 32'd2);
        chk("fd_twice", fd_cnt, 2);
        chk("sb_s_drained", q_s.size(), 0);

        // Asynchronous reset in the middle of a line.
        sb_s = 1'b0;
        pat = 2'd0;
        tx_en = 1'b1;
        wait_lvl("to_href_rst", 1, 1'b1, 100, n);
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_href", 32'(s_if.cam_href), 32'd0);
        chk("rst_data", 32'(s_if.cam_data), 32'd0);
        chk("rst_busy", 32'(busy_s), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt_s), 32'd0);
        tick(1);
        q_s.delete();
        sb_s = 1'b1;
        pat = 2'd3;
        push(0, 3, 0);
        push(0, 3, 1);
        rst_n = 1'b1;
        wait_lvl("to_vs_after_rst", 0, 1'b1, 20, n);
        wait_lvl("to_vs_fall_r", 0, 1'b0, 20, n);
        wait_lvl("to_vs_rise_r", 0, 1'b1, 200, n2);
        chk("frame_len_after_rst", n + n2, 164);
        chk("frame_cnt_after_rst", 32'(frame_cnt_s), 32'd1);
        tx_en = 1'b0;
        wait_lvl("to_idle_r", 2, 1'b0, 400, n);
        chk("sb_s_drained_r", q_s.size(), 0);
        chk("frame_cnt_r2", 32'(frame_cnt_s), 32'd2);

        // 64x64: checkerboard then gray ramp.
        push(1, 2, 0);
        push(1, 1, 1);
        pat_b = 2'd2;
        tx_en_b = 1'b1;
        wait_lvl("to_vs_b", 3, 1'b1, 20, n);
        pat_b = 2'd1;
        wait_lvl("to_vs_b_fall", 3, 1'b0, 20, n);
        wait_lvl("to_vs_b2", 3, 1'b1, 9000, n);
        chk("frame_len_b", n + 4, 8588);
        chk("chk_32_0", 32'(cap[0][32]), 32'hFFFF);
        chk("chk_0_0", 32'(cap[0][0]), 32'h0000);
        chk("chk_32_32", 32'(cap[32][32]), 32'h0000);
        chk("chk_0_32", 32'(cap[32][0]), 32'hFFFF);
        tx_en_b = 1'b0;
        wait_lvl("to_idle_b", 4, 1'b0, 9000, n);
        chk("ramp_63", 32'(cap[0][63]), 32'h39E7);
        chk("ramp_8", 32'(cap[10][8]), 32'h0841);
        chk("ramp_0", 32'(cap[63][0]), 32'h0000);
        chk("sb_b_drained", q_b.size(), 0);
        chk("frame_cnt_b", 32'(frame_cnt_b), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
